execute_stage_param: RTL
========================

EXECUTE_STAGE_PARAM -- requirements
Module: execute_stage_param

Interface
REQ-001 Parameter WIDTH, default 64: datapath width of valC/valA/valB/valE; legal values 16, 32 and 64.
REQ-002 Parameter MUL_EN, default 1: 1 enables the iterative multiply OPq (ifun 4); 0 makes ifun 4 behave as add.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 d_stat  in  4  decode status (AOK = 4'b1000).
REQ-007 d_icode / d_ifun  in  4 each  decode instruction code and function.
REQ-008 d_valC / d_valA / d_valB  in  WIDTH each  decode operands.
REQ-009 d_dstE / d_dstM  in  4 each  destination register IDs (4'hF = none).
REQ-010 E_stall  in  1  hold the E register.
REQ-011 E_bubble  in  1  load a nop into the E register.
REQ-012 m_stat / W_stat  in  4 each  downstream status, gates CC updates.
REQ-013 e_stat / e_icode  out  4 each  status and icode to the memory stage.
REQ-014 e_valE / e_valA  out  WIDTH each  ALU result and pass-through valA.
REQ-015 e_dstE / e_dstM  out  4 each  destinations to the memory stage.
REQ-016 e_Cnd  out  1  condition result.
REQ-017 e_busy  out  1  multiply in progress; upstream must stall F/D.
REQ-018 cc_out  out  3  {ZF, SF, OF}.

Function
REQ-019 E register update on rising clk: E_bubble (highest priority, ignored while e_busy) -> icode 1, ifun 0, stat AOK, vals 0, dstE/dstM 4'hF; else E_stall or e_busy -> hold; else -> capture d_*.
REQ-020 aluA: valA for icode 2 or 6; valC for icode 3, 4 or 5; -8 (WIDTH-bit) for icode 8 or A; +8 for icode 9 or B; 0 otherwise.
REQ-021 aluB: valB for icode 4, 5, 6, 8, 9, A or B; 0 otherwise.
REQ-022 alufun = ifun for icode 6; add for every other icode. ifun 0: B+A; 1: B-A; 2: B&A; 3: B^A; 4: B*A, low WIDTH bits; ifun >4 behaves as add. All results are modulo 2^WIDTH.
REQ-023 Single-cycle ops are combinational from the E register to e_valE (latency 0 after capture).
REQ-024 Multiply FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on the clock edge after an icode 6/ifun 4 capture (MUL_EN=1).
  - RUN: radix-2 shift-add for exactly WIDTH cycles.
  - RUN->DONE after WIDTH cycles.
  - DONE->IDLE after 1 cycle.
REQ-025 e_busy is high from the first cycle an ifun-4 OPq occupies the E register through RUN, and low in DONE; e_valE carries the product only in DONE.
REQ-026 While e_busy: e_icode=1, e_stat=AOK, e_dstE=e_dstM=4'hF, e_Cnd=0, so downstream sees a bubble.
REQ-027 CC update at rising clk iff E_icode==6, not busy, m_stat==AOK and W_stat==AOK.
  - ZF = (valE==0); SF = valE[WIDTH-1].
  - OF for add: aluA and aluB have equal sign and the result sign differs.
  - OF for sub: aluA and aluB have opposite sign and the result sign differs from aluB.
  - OF = 0 for and, xor and mul.
REQ-028 e_Cnd is evaluated on the current CC, and only for icode 2 or 7: ifun 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; ifun >6 gives 0. All other icodes give e_Cnd=0.
REQ-029 e_dstE = 4'hF when icode 2 and e_Cnd=0; otherwise E_dstE. e_valA = E_valA; e_dstM = E_dstM; e_stat/e_icode follow the E register except when REQ-026 applies.
REQ-030 A non-AOK E_stat passes through unchanged and suppresses the CC update for that instruction.

Reset
REQ-031 rst_n low asynchronously forces:
  - E register to the nop of REQ-019;
  - CC = 3'b100;
  - FSM = IDLE, e_busy=0, e_Cnd=0, e_valE=0.
REQ-032 Reset asserted mid-multiply aborts the multiply with no CC write; after release, the first capture is a normal one.

Verification
REQ-033 WIDTH=64, OPq sub, valA=5, valB=5, all stat AOK -> e_valE=0, cc_out=3'b100 after the edge; a following jle gives e_Cnd=1.
REQ-034 WIDTH=32, OPq add, valA=valB=32'h7FFFFFFF -> e_valE=32'hFFFFFFFE, cc_out=3'b011.
REQ-035 OPq sub with m_stat=4'b0010 -> e_valE computed, cc_out unchanged.
REQ-036 cmovne with ZF=1, d_dstE=3 -> e_Cnd=0, e_dstE=4'hF.
REQ-037 WIDTH=16, mul, valA=7, valB=9 -> e_busy high for 17 cycles; DONE gives e_valE=63 and cc_out=3'b000; E_bubble while busy is ignored.
REQ-038 rst_n pulsed low during RUN -> e_busy=0, cc_out=3'b100, e_icode=1 immediately.

Source files
------------

// File: rtl/execute_stage_param.sv
// Y86-style execute stage: E pipeline register, ALU with an optional iterative
// radix-2 multiply, condition codes and branch/cmov condition evaluation.
module execute_stage_param #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic [3:0]       e_stat,
  output logic [3:0]       e_icode,
  output logic [WIDTH-1:0] e_valE,
  output logic [WIDTH-1:0] e_valA,
  output logic [3:0]       e_dstE,
  output logic [3:0]       e_dstM,
  output logic             e_Cnd,
  output logic             e_busy,
  output logic [2:0]       cc_out
);
  localparam logic [3:0] AOK    = 4'b1000;
  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
  localparam logic [WIDTH-1:0] NEG8 = ~WIDTH'(7);

  typedef struct packed {
    logic [3:0]       stat;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valC;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
  } ereg_t;

  localparam ereg_t E_NOP = '{stat: AOK, icode: I_NOP, ifun: 4'h0, valC: '0,
                              valA: '0, valB: '0, dstE: RNONE, dstM: RNONE};

  typedef enum logic [1:0] {IDLE, RUN, DONE} mst_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MUL} alu_op_t;

  ereg_t            e_q, d_in;
  mst_t             st;
  logic             busy_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [2:0]       cc;
  logic [WIDTH-1:0] alu_a, alu_b, val_e, sum, diff;
  alu_op_t          alu_op;
  logic             of, cc_upd, cnd_raw, cnd, capture, d_is_mul, e_is_mul;

  assign d_in = '{stat: d_stat, icode: d_icode, ifun: d_ifun, valC: d_valC,
                  valA: d_valA, valB: d_valB, dstE: d_dstE, dstM: d_dstM};

  // A running multiply owns the E register: bubble and capture both wait.
  assign capture  = !busy_q && !E_bubble && !E_stall;
  assign d_is_mul = MUL_EN && (d_icode == I_OPQ) && (d_ifun == 4'h4);
  assign e_is_mul = MUL_EN && (e_q.icode == I_OPQ) && (e_q.ifun == 4'h4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    e_q <= E_NOP;
    else if (E_bubble && !busy_q)  e_q <= E_NOP;
    else if (capture)              e_q <= d_in;
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_q.icode)
      4'h2, 4'h6:        alu_a = e_q.valA;
      4'h3, 4'h4, 4'h5:  alu_a = e_q.valC;
      4'h8, 4'hA:        alu_a = NEG8;
      4'h9, 4'hB:        alu_a = POS8;
      default:           alu_a = '0;
    endcase
    case (e_q.icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = e_q.valB;
      default:                                  alu_b = '0;
    endcase
  end

  always_comb begin
    alu_op = OP_ADD;
    if (e_q.icode == I_OPQ) begin
      case (e_q.ifun)
        4'h1:    alu_op = OP_SUB;
        4'h2:    alu_op = OP_AND;
        4'h3:    alu_op = OP_XOR;
        4'h4:    alu_op = MUL_EN ? OP_MUL : OP_ADD;
        default: alu_op = OP_ADD;
      endcase
    end
  end

  assign sum  = alu_b + alu_a;
  assign diff = alu_b - alu_a;

  always_comb begin
    val_e = sum;
    of    = 1'b0;
    case (alu_op)
      OP_SUB: begin
        val_e = diff;
        of    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_b[WIDTH-1]);
      end
      OP_AND:  val_e = alu_b & alu_a;
      OP_XOR:  val_e = alu_b ^ alu_a;
      // the product is only exposed once the shift-add has finished
      OP_MUL:  val_e = (st == DONE) ? acc : '0;
      default: begin
        val_e = sum;
        of    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
    endcase
  end

  assign cc_upd = (e_q.icode == I_OPQ) && !busy_q && (e_q.stat == AOK) &&
                  (m_stat == AOK) && (W_stat == AOK) && !(e_is_mul && st != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cc <= 3'b100;
    else if (cc_upd) cc <= {val_e == '0, val_e[WIDTH-1], of};
  end

  // Multiply sequencer: one IDLE cycle with the op latched, WIDTH shift-add
  // steps in RUN, then a single DONE cycle presenting the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      busy_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (st)
        IDLE: if (busy_q) begin
          st     <= RUN;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= alu_a;
          mplier <= alu_b;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            st     <= DONE;
            busy_q <= 1'b0;
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
      if (capture && d_is_mul) busy_q <= 1'b1;
    end
  end

  always_comb begin
    case (e_q.ifun)
      4'h0:    cnd_raw = 1'b1;
      4'h1:    cnd_raw = (cc[1] ^ cc[0]) | cc[2];
      4'h2:    cnd_raw = cc[1] ^ cc[0];
      4'h3:    cnd_raw = cc[2];
      4'h4:    cnd_raw = !cc[2];
      4'h5:    cnd_raw = !(cc[1] ^ cc[0]);
      4'h6:    cnd_raw = !(cc[1] ^ cc[0]) && !cc[2];
      default: cnd_raw = 1'b0;
    endcase
  end

  assign cnd = !busy_q && ((e_q.icode == I_CMOV) || (e_q.icode == I_JXX)) && cnd_raw;

  // While multiplying, downstream sees a bubble.
  assign e_stat  = busy_q ? AOK   : e_q.stat;
  assign e_icode = busy_q ? I_NOP : e_q.icode;
  assign e_dstE  = (busy_q || (e_q.icode == I_CMOV && !cnd)) ? RNONE : e_q.dstE;
  assign e_dstM  = busy_q ? RNONE : e_q.dstM;
  assign e_valE  = val_e;
  assign e_valA  = e_q.valA;
  assign e_Cnd   = cnd;
  assign e_busy  = busy_q;
  assign cc_out  = cc;

endmodule
